// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding, IO width and frame-size helper for the scan chain controller.
package scan_ctrl_pkg;

  // Each scan wrapper carries this many input bits and this many output bits.
  localparam int IO_BITS = 8;

  // State codes kept as plain constants so older tooling can still decode them.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    CAPTURE = ST_CAPTURE,
    SHIFT   = ST_SHIFT,
    LATCH   = ST_LATCH,
    DONE    = ST_DONE
  } state_e;

  // Number of scan bits in one frame for a chain of n wrappers.
  function automatic int frame_bits(input int n);
    return n * IO_BITS;
  endfunction

endpackage

// File: rtl/scan_chain_controller_if.sv
// Request/response handshake between the host logic and the scan chain controller.
interface scan_chain_controller_if #(
  parameter int SEL_W = 2
) ();
  import scan_ctrl_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   req_sel;
  logic [IO_BITS-1:0] req_data;
  logic               rsp_valid;
  logic [IO_BITS-1:0] rsp_data;
  logic               rsp_err;

  // Host side: issues requests, consumes responses.
  modport master (
    output req_valid, req_sel, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_sel, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/scan_phase_gen.sv
// Scan-clock phase timer: counts HALF_PERIOD cycles per half and flags the last
// cycle of the low and high halves. Held cleared whenever i_run is low so every
// active state starts at the beginning of a low half.
module scan_phase_gen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_run,
  output logic o_low_last,
  output logic o_high_last,
  output logic o_half_next
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

  logic [PW-1:0] r_phase;
  logic          r_half;
  logic          w_phase_last;

  assign w_phase_last = (r_phase == PH_LAST);
  assign o_low_last   = i_run && w_phase_last && !r_half;
  assign o_high_last  = i_run && w_phase_last && r_half;
  // Level the scan clock takes in the next cycle (0 = low half).
  assign o_half_next  = i_run && (r_half ^ w_phase_last);

  // Advance the phase counter, flipping the half at the end of each half period.
  always_ff @(posedge clk_in) begin
    if (rst_in || !i_run) begin
      r_phase <= '0;
      r_half  <= 1'b0;
    end else if (w_phase_last) begin
      r_phase <= '0;
      r_half  <= ~r_half;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

endmodule

// File: rtl/scan_chain_controller.sv
// Scan chain controller: per request captures all wrapper outputs, shifts one
// full frame (target byte in, old outputs out) and latches the new inputs.
// Every scan_* output is a flop whose next value is decoded from the next
// state, so the chain sees clean edges aligned to clk_in.
module scan_chain_controller
  import scan_ctrl_pkg::*;
#(
  parameter int NUM_DESIGNS = 4,
  parameter int HALF_PERIOD = 2,
  // May be set wider than needed so out-of-range selects can be presented.
  parameter int SEL_W = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  scan_chain_controller_if.slave  bus,
  output logic                    scan_clk_out,
  output logic                    scan_data_out,
  output logic                    scan_latch_out,
  output logic                    scan_select_out,
  input  logic                    scan_data_in
);

  localparam int L     = frame_bits(NUM_DESIGNS);
  localparam int BW    = $clog2(L + 1);
  localparam int FW    = $clog2(L);
  localparam int LSB_W = $clog2(IO_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(L - 1);
  localparam logic [FW-1:0] LAST_POS = FW'(L - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [BW-1:0]      r_bit;
  logic [BW-1:0]      w_bit_next;
  logic [SEL_W-1:0]   r_sel;
  logic [IO_BITS-1:0] r_data;
  logic [IO_BITS-1:0] r_cap;
  logic [IO_BITS-1:0] r_rsp_data;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic               r_scan_clk;
  logic               r_scan_data;
  logic               r_scan_latch;
  logic               r_scan_select;

  logic               w_run;
  logic               w_low_last;
  logic               w_high_last;
  logic               w_half_next;
  logic               w_accept;
  logic               w_req_err;
  logic [L-1:0]       w_frame;
  logic [L-1:0]       w_mask;
  logic [FW-1:0]      w_pos;
  logic [FW-1:0]      w_pos_next;

  assign w_run     = (r_state == CAPTURE) || (r_state == SHIFT) || (r_state == LATCH);
  assign w_accept  = (r_state == IDLE) && bus.req_valid;
  assign w_req_err = int'(bus.req_sel) >= NUM_DESIGNS;

  // Bit i of the shift carries chain position L-1-i (position = 8*design + bit).
  assign w_pos      = LAST_POS - r_bit[FW-1:0];
  assign w_pos_next = LAST_POS - w_bit_next[FW-1:0];

  // Frame image: target byte at its wrapper slot, zero elsewhere; mask marks the slot.
  for (genvar gi = 0; gi < NUM_DESIGNS; gi++) begin : g_frame
    assign w_frame[gi*IO_BITS +: IO_BITS] = (r_sel == SEL_W'(gi)) ? r_data : '0;
    assign w_mask[gi*IO_BITS +: IO_BITS]  = {IO_BITS{r_sel == SEL_W'(gi)}};
  end

  scan_phase_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_phase (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_run       (w_run),
    .o_low_last  (w_low_last),
    .o_high_last (w_high_last),
    .o_half_next (w_half_next)
  );

  assign bus.req_ready = (r_state == IDLE) && !rst_in;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  assign scan_clk_out    = r_scan_clk;
  assign scan_data_out   = r_scan_data;
  assign scan_latch_out  = r_scan_latch;
  assign scan_select_out = r_scan_select;

  // Next-state and bit-counter decode; each active state ends on a high-half boundary.
  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_state_next = w_req_err ? DONE : CAPTURE;
          w_bit_next   = '0;
        end
      end
      CAPTURE: begin
        if (w_high_last) begin
          w_state_next = SHIFT;
          w_bit_next   = '0;
        end
      end
      SHIFT: begin
        if (w_high_last) begin
          if (r_bit == LAST_BIT) begin
            w_state_next = LATCH;
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end
      end
      LATCH: begin
        if (w_high_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and bit counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_bit   <= w_bit_next;
    end
  end

  // Hold the accepted request and collect the target's output bits as they leave the chain.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sel  <= '0;
      r_data <= '0;
      r_cap  <= '0;
    end else if (w_accept) begin
      r_sel  <= bus.req_sel;
      r_data <= bus.req_data;
      r_cap  <= '0;
    end else if ((r_state == SHIFT) && w_low_last && w_mask[w_pos]) begin
      r_cap[w_pos[LSB_W-1:0]] <= scan_data_in;
    end
  end

  // Response: one-cycle valid in DONE; data/err held until the next response.
  // The only way into DONE straight from IDLE is a rejected select.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= (w_state_next == DONE);
      if (w_state_next == DONE) begin
        r_rsp_err  <= w_accept;
        r_rsp_data <= w_accept ? '0 : r_cap;
      end
    end
  end

  // Scan pin flops, decoded from the state/half/bit the next cycle will have.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_scan_clk    <= 1'b0;
      r_scan_data   <= 1'b0;
      r_scan_latch  <= 1'b0;
      r_scan_select <= 1'b0;
    end else begin
      r_scan_select <= (w_state_next == CAPTURE);
      r_scan_clk    <= w_half_next && ((w_state_next == CAPTURE) || (w_state_next == SHIFT));
      r_scan_latch  <= !w_half_next && (w_state_next == LATCH);
      r_scan_data   <= (w_state_next == SHIFT) && w_frame[w_pos_next];
    end
  end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller with behavioural scan wrappers on the chain.
module tb_scan_chain_controller;

  localparam int NUM_DESIGNS = 4;
  localparam int HALF_PERIOD = 2;
  localparam int SEL_W       = 3;
  localparam int L           = NUM_DESIGNS * 8;
  localparam int LAT         = 2 * HALF_PERIOD * (L + 2);

  logic clk_in = 1'b0;
  logic rst_in;
  logic scan_clk_out, scan_data_out, scan_latch_out, scan_select_out, scan_data_in;

  scan_chain_controller_if #(.SEL_W(SEL_W)) bus ();

  scan_chain_controller #(
    .NUM_DESIGNS (NUM_DESIGNS),
    .HALF_PERIOD (HALF_PERIOD),
    .SEL_W       (SEL_W)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .bus             (bus),
    .scan_clk_out    (scan_clk_out),
    .scan_data_out   (scan_data_out),
    .scan_latch_out  (scan_latch_out),
    .scan_select_out (scan_select_out),
    .scan_data_in    (scan_data_in)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural chain: one long shift register, position p = 8*design + bit.
  logic [L-1:0] chain = '0;
  logic [7:0]   design_out [NUM_DESIGNS];
  logic [7:0]   design_in  [NUM_DESIGNS] = '{default: 8'h00};
  logic [7:0]   exp_in     [NUM_DESIGNS] = '{default: 8'h00};
  int n_cap_rise = 0, n_shift_rise = 0, n_latch_rise = 0, n_rsp = 0, n_scan_act = 0;
  int n_tests = 0, n_fail = 0;

  assign scan_data_in = chain[L-1];

  always @(posedge scan_clk_out) begin
    if (scan_select_out) begin
      for (int d = 0; d < NUM_DESIGNS; d++) chain[8*d +: 8] <= design_out[d];
      n_cap_rise <= n_cap_rise + 1;
    end else begin
      chain        <= {chain[L-2:0], scan_data_out};
      n_shift_rise <= n_shift_rise + 1;
    end
  end

  always @(posedge scan_latch_out) begin
    for (int d = 0; d < NUM_DESIGNS; d++) design_in[d] <= chain[8*d +: 8];
    n_latch_rise <= n_latch_rise + 1;
  end

  always @(posedge clk_in) begin
    if (bus.rsp_valid) n_rsp <= n_rsp + 1;
    if (scan_clk_out | scan_data_out | scan_latch_out | scan_select_out)
      n_scan_act <= n_scan_act + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] scan_pins();
    return 32'({scan_clk_out, scan_data_out, scan_latch_out, scan_select_out});
  endfunction

  // One request/response; expectations come from the wrapper rules, not the DUT.
  task automatic run_req(input int sel, input logic [7:0] data, input bit hold);
    int k, busy_ready, rsp0, cap0, sh0, la0, act0;
    logic [7:0] exp_data;
    bit exp_err;
    exp_err  = (sel >= NUM_DESIGNS);
    exp_data = 8'h00;
    if (!exp_err) exp_data = design_out[sel];
    rsp0 = n_rsp; cap0 = n_cap_rise; sh0 = n_shift_rise; la0 = n_latch_rise; act0 = n_scan_act;
    @(negedge clk_in);
    bus.req_valid = 1'b1;
    bus.req_sel   = SEL_W'(sel);
    bus.req_data  = data;
    check("ready_idle", bus.req_ready, 1);
    @(posedge clk_in);  // accept edge
    k = 0;
    busy_ready = 0;
    @(negedge clk_in);
    if (!hold) bus.req_valid = 1'b0;
    while (!bus.rsp_valid && k < LAT + 20) begin
      if (bus.req_ready) busy_ready++;
      @(posedge clk_in);
      k++;
      @(negedge clk_in);
    end
    bus.req_valid = 1'b0;
    // Rejected selects answer in the cycle straight after the accept edge.
    check("latency", k, exp_err ? 0 : LAT);
    check("rsp_err", bus.rsp_err, exp_err);
    check("rsp_data", bus.rsp_data, exp_data);
    check("ready_busy", busy_ready, 0);
    repeat (3) @(negedge clk_in);
    check("rsp_data_hold", bus.rsp_data, exp_data);
    check("rsp_count", n_rsp - rsp0, 1);
    check("capture_rises", n_cap_rise - cap0, exp_err ? 0 : 1);
    check("shift_rises", n_shift_rise - sh0, exp_err ? 0 : L);
    check("latch_rises", n_latch_rise - la0, exp_err ? 0 : 1);
    if (exp_err) check("err_no_scan", n_scan_act - act0, 0);
    if (!exp_err)
      for (int d = 0; d < NUM_DESIGNS; d++) exp_in[d] = (d == sel) ? data : 8'h00;
    for (int d = 0; d < NUM_DESIGNS; d++) check("design_in", design_in[d], exp_in[d]);
    $display("[TB] req sel=%0d data=%02h hold=%0d -> rsp_data=%02h err=%0d latency=%0d",
             sel, data, hold, bus.rsp_data, bus.rsp_err, k);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, sh0, rsp0;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    bus.req_data  = '0;
    rst_in        = 1'b1;
    for (int d = 0; d < NUM_DESIGNS; d++) design_out[d] = 8'($urandom);

    // Reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_ready", bus.req_ready, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    check("reset_scan", scan_pins(), 0);
    rst_in = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      check("idle_scan", scan_pins(), 0);
      check("idle_ready", bus.req_ready, 1);
      check("idle_rsp_valid", bus.rsp_valid, 0);
    end

    // Directed transactions
    run_req(2, 8'hA5, 1'b0);
    design_out[2] = 8'h3C;
    run_req(2, 8'h96, 1'b0);
    run_req(5, 8'hFF, 1'b0);
    run_req(1, 8'h5A, 1'b1);
    run_req(0, 8'h81, 1'b0);
    run_req(3, 8'h01, 1'b0);

    // Randomized transactions
    repeat (6) begin
      for (int d = 0; d < NUM_DESIGNS; d++) design_out[d] = 8'($urandom);
      run_req(int'($urandom_range(0, 5)), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of SHIFT, then a clean request
    sh0 = n_shift_rise;
    @(negedge clk_in);
    bus.req_valid = 1'b1;
    bus.req_sel   = SEL_W'(1);
    bus.req_data  = 8'hC3;
    @(negedge clk_in);
    bus.req_valid = 1'b0;
    k = 0;
    while ((n_shift_rise - sh0) < 10 && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    check("midshift_reached", n_shift_rise - sh0, 10);
    rsp0 = n_rsp;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_scan", scan_pins(), 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_ready", bus.req_ready, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("after_rst_ready", bus.req_ready, 1);
    check("after_rst_scan", scan_pins(), 0);
    repeat (5) @(negedge clk_in);
    check("after_rst_no_rsp", n_rsp - rsp0, 0);
    design_out[1] = 8'h7E;
    run_req(1, 8'h24, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
